// File: rtl/hpdcache_perf_csr_pkg.sv
// Shared types and constants for the HPDcache CSR/performance-counter controller.
package hpdcache_perf_csr_pkg;

    localparam int NB_EVT = 8;

    typedef enum logic [3:0] {
        CSR_CFG  = 4'd0,
        CSR_CTRL = 4'd1,
        CSR_CNT0 = 4'd2,
        CSR_CNT1 = 4'd3,
        CSR_CNT2 = 4'd4,
        CSR_CNT3 = 4'd5,
        CSR_CNT4 = 4'd6,
        CSR_CNT5 = 4'd7,
        CSR_CNT6 = 4'd8,
        CSR_CNT7 = 4'd9
    } csr_addr_e;

    localparam int CFG_ENABLE             = 0;
    localparam int CFG_WBUF_RESET_TIMECNT = 1;
    localparam int CFG_WBUF_SEQ_WAW       = 2;
    localparam int CFG_WBUF_INHIBIT_COAL  = 3;
    localparam int CFG_HWPF_STRIDE_PLRU   = 4;
    localparam int CFG_ERR_CACHEABLE_AMO  = 5;
    localparam int CFG_RTAB_SINGLE_ENTRY  = 6;
    localparam int CFG_DEFAULT_WB         = 7;
    localparam int CFG_THRESH_LSB         = 8;

    localparam int CTRL_CLR  = 0;
    localparam int CTRL_FRZ  = 1;
    localparam int CTRL_SNAP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hpdcache_perf_csr_if.sv
// Single-outstanding valid/ready CSR request/response port.
interface hpdcache_perf_csr_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [3:0]       req_addr;
    logic [CNT_W-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/hpdcache_perf_sat_counter.sv
// Saturating event counter with synchronous clear (dominant) and freeze.
module hpdcache_perf_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             frz_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear beats increment, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && !frz_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hpdcache_perf_csr_ctrl.sv
// CSR controller: owns HPDcache cfg bits, defers write-buffer config changes until drained, exposes counters.
// Optional HPDCACHE_PERF_SNAPSHOT_EN: CTRL b2 snapshots all counters and CNT reads return the snapshot.
module hpdcache_perf_csr_ctrl
    import hpdcache_perf_csr_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned WBUF_TC_W     = 8,
    parameter int unsigned THRESH_RST    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hpdcache_perf_csr_if.slave    csr,
    input  logic [NB_EVT-1:0]     evt_i,
    input  logic                  wbuf_empty_i,
    output logic                  cfg_enable_o,
    output logic                  cfg_wbuf_reset_timecnt_on_write_o,
    output logic                  cfg_wbuf_sequential_waw_o,
    output logic                  cfg_wbuf_inhibit_write_coalescing_o,
    output logic                  cfg_hwpf_stride_updt_plru_o,
    output logic                  cfg_error_on_cacheable_amo_o,
    output logic                  cfg_rtab_single_entry_o,
    output logic                  cfg_default_wb_o,
    output logic [WBUF_TC_W-1:0]  cfg_wbuf_threshold_o
);
    localparam int unsigned CFG_W = CFG_THRESH_LSB + WBUF_TC_W;
    localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CFG_W-1:0] CFG_RST = {WBUF_TC_W'(THRESH_RST), 8'h00};

    ctrl_state_e      state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d, pend_q, pend_d, cfg_wr_s;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             frozen_q, frozen_d, ready_q, ready_d, err_q, err_d;
    logic [CNT_W-1:0] rdata_q, rdata_d;
    logic             acc_s, clr_s, wb_chg_s;
    logic [2:0]       cnt_idx_s;
    logic [CNT_W-1:0] cnt_s    [NB_EVT];
    logic [CNT_W-1:0] cnt_rd_s [NB_EVT];
`ifdef HPDCACHE_PERF_SNAPSHOT_EN
    logic             snap_s;
    logic [CNT_W-1:0] shadow_q [NB_EVT];
    logic [CNT_W-1:0] shadow_d [NB_EVT];
`endif

    assign acc_s     = csr.req_valid && ready_q;
    assign cfg_wr_s  = CFG_W'(csr.req_wdata);
    assign cnt_idx_s = 3'(csr.req_addr - CSR_CNT0);
    // only the write-buffer knobs (bits 3:1 and the threshold) need an empty write buffer
    assign wb_chg_s  = (cfg_wr_s[CFG_WBUF_INHIBIT_COAL:CFG_WBUF_RESET_TIMECNT]
                        != cfg_q[CFG_WBUF_INHIBIT_COAL:CFG_WBUF_RESET_TIMECNT])
                    || (cfg_wr_s[CFG_W-1:CFG_THRESH_LSB] != cfg_q[CFG_W-1:CFG_THRESH_LSB]);

    // request decode, drain sequencing and response capture
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        frozen_d = frozen_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        clr_s    = 1'b0;
`ifdef HPDCACHE_PERF_SNAPSHOT_EN
        snap_s   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    state_d = ST_RESP;
                    rdata_d = {CNT_W{1'b0}};
                    err_d   = 1'b0;
                    if (csr.req_addr == CSR_CFG) begin
                        if (!csr.req_we) begin
                            rdata_d = CNT_W'(cfg_q);
                        end else if (wb_chg_s && !wbuf_empty_i) begin
                            pend_d  = cfg_wr_s;
                            tmo_d   = {TMO_W{1'b0}};
                            state_d = ST_DRAIN;
                        end else begin
                            cfg_d = cfg_wr_s;
                        end
                    end else if (csr.req_addr == CSR_CTRL) begin
                        if (csr.req_we) begin
                            clr_s    = cfg_wr_s[CTRL_CLR];
                            frozen_d = cfg_wr_s[CTRL_FRZ];
`ifdef HPDCACHE_PERF_SNAPSHOT_EN
                            snap_s   = cfg_wr_s[CTRL_SNAP];
`endif
                        end else begin
                            rdata_d = CNT_W'({frozen_q, 1'b0});
                        end
                    end else if (csr.req_addr <= CSR_CNT7) begin
                        if (csr.req_we) begin
                            err_d = 1'b1;
                        end else begin
                            rdata_d = cnt_rd_s[cnt_idx_s];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (wbuf_empty_i) begin
                    cfg_d   = pend_q;
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (csr.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // controller state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cfg_q    <= CFG_RST;
            pend_q   <= {CFG_W{1'b0}};
            tmo_q    <= {TMO_W{1'b0}};
            frozen_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
            frozen_q <= frozen_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    for (genvar k = 0; k < NB_EVT; k++) begin : g_cnt
        hpdcache_perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (evt_i[k]),
            .clr_i (clr_s),
            .frz_i (frozen_q),
            .cnt_o (cnt_s[k])
        );
    end

`ifdef HPDCACHE_PERF_SNAPSHOT_EN
    // shadow copy: clear wins over snapshot
    always_comb begin
        for (int i = 0; i < NB_EVT; i++) begin
            if (clr_s) begin
                shadow_d[i] = {CNT_W{1'b0}};
            end else if (snap_s) begin
                shadow_d[i] = cnt_s[i];
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
    end

    // shadow registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_EVT; i++) shadow_q[i] <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NB_EVT; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign cnt_rd_s = shadow_q;
`else
    assign cnt_rd_s = cnt_s;
`endif

    assign csr.req_ready = ready_q;
    assign csr.rsp_valid = (state_q == ST_RESP);
    assign csr.rsp_rdata = rdata_q;
    assign csr.rsp_err   = err_q;

    assign cfg_enable_o                        = cfg_q[CFG_ENABLE];
    assign cfg_wbuf_reset_timecnt_on_write_o   = cfg_q[CFG_WBUF_RESET_TIMECNT];
    assign cfg_wbuf_sequential_waw_o           = cfg_q[CFG_WBUF_SEQ_WAW];
    assign cfg_wbuf_inhibit_write_coalescing_o = cfg_q[CFG_WBUF_INHIBIT_COAL];
    assign cfg_hwpf_stride_updt_plru_o         = cfg_q[CFG_HWPF_STRIDE_PLRU];
    assign cfg_error_on_cacheable_amo_o        = cfg_q[CFG_ERR_CACHEABLE_AMO];
    assign cfg_rtab_single_entry_o             = cfg_q[CFG_RTAB_SINGLE_ENTRY];
    assign cfg_default_wb_o                    = cfg_q[CFG_DEFAULT_WB];
    assign cfg_wbuf_threshold_o                = cfg_q[CFG_W-1:CFG_THRESH_LSB];
endmodule

// File: tb/tb_hpdcache_perf_csr_ctrl.sv
// Directed scoreboard bench: a 32-bit instance for the CSR map/drain flow and a 4-bit instance for saturation.
module tb_hpdcache_perf_csr_ctrl;
    localparam int DRAIN_TIMEOUT = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] evt  = 8'h00;
    logic [7:0] evt4 = 8'h00;
    logic wbuf_empty = 1'b1;
    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q [$];

    hpdcache_perf_csr_if #(.CNT_W(32)) b ();
    hpdcache_perf_csr_if #(.CNT_W(4))  b4 ();

    logic c_en, c_rtw, c_waw, c_coal, c_plru, c_amo, c_rtab, c_wb;
    logic [7:0] c_thr;
    logic d_en, d_rtw, d_waw, d_coal, d_plru, d_amo, d_rtab, d_wb;
    logic [7:0] d_thr;

    always #5 clk = ~clk;

    hpdcache_perf_csr_ctrl #(.CNT_W(32), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .csr(b), .evt_i(evt), .wbuf_empty_i(wbuf_empty),
        .cfg_enable_o(c_en), .cfg_wbuf_reset_timecnt_on_write_o(c_rtw),
        .cfg_wbuf_sequential_waw_o(c_waw), .cfg_wbuf_inhibit_write_coalescing_o(c_coal),
        .cfg_hwpf_stride_updt_plru_o(c_plru), .cfg_error_on_cacheable_amo_o(c_amo),
        .cfg_rtab_single_entry_o(c_rtab), .cfg_default_wb_o(c_wb), .cfg_wbuf_threshold_o(c_thr)
    );

    hpdcache_perf_csr_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .csr(b4), .evt_i(evt4), .wbuf_empty_i(1'b1),
        .cfg_enable_o(d_en), .cfg_wbuf_reset_timecnt_on_write_o(d_rtw),
        .cfg_wbuf_sequential_waw_o(d_waw), .cfg_wbuf_inhibit_write_coalescing_o(d_coal),
        .cfg_hwpf_stride_updt_plru_o(d_plru), .cfg_error_on_cacheable_amo_o(d_amo),
        .cfg_rtab_single_entry_o(d_rtab), .cfg_default_wb_o(d_wb), .cfg_wbuf_threshold_o(d_thr)
    );

    function automatic logic rdy(input bit s4);
        return s4 ? b4.req_ready : b.req_ready;
    endfunction
    function automatic logic vld(input bit s4);
        return s4 ? b4.rsp_valid : b.rsp_valid;
    endfunction
    function automatic logic [31:0] rdat(input bit s4);
        return s4 ? 32'(b4.rsp_rdata) : b.rsp_rdata;
    endfunction
    function automatic logic rerr(input bit s4);
        return s4 ? b4.rsp_err : b.rsp_err;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input bit s4, input bit we, input logic [3:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit imm);
        int n;
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        exp_q.push_back(e);
        @(negedge clk);
        if (s4) begin
            b4.req_valid = 1'b1; b4.req_we = we; b4.req_addr = a; b4.req_wdata = wd[3:0];
        end else begin
            b.req_valid = 1'b1; b.req_we = we; b.req_addr = a; b.req_wdata = wd;
        end
        n = 0;
        while (!rdy(s4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(rdy(s4)), 32'd1);
        @(posedge clk);
        #1;
        b.req_valid  = 1'b0;
        b4.req_valid = 1'b0;
        if (imm) check("rsp_latency", 32'(vld(s4)), 32'd1);
    endtask

    task automatic recv(input bit s4, input string tag, input int hold);
        int n;
        exp_t e;
        n = 0;
        while (!vld(s4) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(vld(s4)), 32'd1);
        check({tag, "_sb_depth"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{32'd0, 1'b0};
        check({tag, "_rdata"}, rdat(s4), e.rdata);
        check({tag, "_err"}, 32'(rerr(s4)), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(vld(s4)), 32'd1);
            check({tag, "_hold_rdata"}, rdat(s4), e.rdata);
        end
        if (s4) b4.rsp_ready = 1'b1;
        else b.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b.rsp_ready  = 1'b0;
        b4.rsp_ready = 1'b0;
    endtask

    task automatic access(input bit s4, input bit we, input logic [3:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input string tag);
        send(s4, we, a, wd, er, ee, 1'b1);
        recv(s4, tag, 0);
    endtask

    task automatic pulse(input logic [7:0] v, input int cycles);
        @(negedge clk);
        evt = v;
        repeat (cycles) @(negedge clk);
        evt = 8'h00;
    endtask

    initial begin
        int n;
        b.req_valid = 1'b0;  b.req_we = 1'b0;  b.req_addr = 4'd0;  b.req_wdata = 32'd0;  b.rsp_ready = 1'b0;
        b4.req_valid = 1'b0; b4.req_we = 1'b0; b4.req_addr = 4'd0; b4.req_wdata = 4'd0; b4.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(b.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        check("rst_rdata", b.rsp_rdata, 32'd0);
        check("rst_err", 32'(b.rsp_err), 32'd0);
        check("rst_cfg_enable", 32'(c_en), 32'd0);
        check("rst_threshold", 32'(c_thr), 32'd4);
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 1'b0, 4'd0, 32'd0, 32'h400, 1'b0, "rd_cfg_rst");
        access(1'b0, 1'b0, 4'd2, 32'd0, 32'd0, 1'b0, "rd_cnt0_rst");

        // event counting and clear
        pulse(8'h02, 5);
        access(1'b0, 1'b0, 4'd3, 32'd0, 32'd5, 1'b0, "rd_cnt1_5");
        access(1'b0, 1'b1, 4'd1, 32'd1, 32'd0, 1'b0, "wr_ctrl_clr");
        access(1'b0, 1'b0, 4'd3, 32'd0, 32'd0, 1'b0, "rd_cnt1_clr");

        // drained config write
        wbuf_empty = 1'b0;
        send(1'b0, 1'b1, 4'd0, 32'h802, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("drain_req_ready", 32'(b.req_ready), 32'd0);
        check("drain_rtw_held", 32'(c_rtw), 32'd0);
        check("drain_thr_held", 32'(c_thr), 32'd4);
        check("drain_no_rsp", 32'(b.rsp_valid), 32'd0);
        wbuf_empty = 1'b1;
        @(posedge clk);
        #1;
        check("drain_rtw_applied", 32'(c_rtw), 32'd1);
        check("drain_thr_applied", 32'(c_thr), 32'd8);
        check("drain_rsp_latency", 32'(b.rsp_valid), 32'd1);
        recv(1'b0, "drain_rsp", 0);

        // drain timeout
        wbuf_empty = 1'b0;
        send(1'b0, 1'b1, 4'd0, 32'h806, 32'd0, 1'b1, 1'b0);
        n = 0;
        while (!b.rsp_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(DRAIN_TIMEOUT));
        check("tmo_waw_held", 32'(c_waw), 32'd0);
        check("tmo_thr_held", 32'(c_thr), 32'd8);
        recv(1'b0, "tmo_rsp", 0);
        wbuf_empty = 1'b1;

        // address errors and ignored upper CFG bits
        access(1'b0, 1'b1, 4'd12, 32'd5, 32'd0, 1'b1, "wr_addr12");
        access(1'b0, 1'b1, 4'd2, 32'd5, 32'd0, 1'b1, "wr_cnt_ro");
        access(1'b0, 1'b0, 4'd15, 32'd0, 32'd0, 1'b1, "rd_addr15");
        access(1'b0, 1'b1, 4'd0, 32'hFFFF_F803, 32'd0, 1'b0, "wr_cfg_wide");
        access(1'b0, 1'b0, 4'd0, 32'd0, 32'h0000_F803, 1'b0, "rd_cfg_wide");
        check("cfg_enable_set", 32'(c_en), 32'd1);
        check("cfg_thr_f8", 32'(c_thr), 32'hF8);

        // 4-bit saturation, then clear colliding with an event
        @(negedge clk);
        evt4 = 8'h01;
        repeat (20) @(negedge clk);
        access(1'b1, 1'b0, 4'd2, 32'd0, 32'd15, 1'b0, "sat_cnt0");
        send(1'b1, 1'b1, 4'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        evt4 = 8'h00;
        recv(1'b1, "sat_clr", 0);
        access(1'b1, 1'b0, 4'd2, 32'd0, 32'd0, 1'b0, "sat_cnt0_clr");

        // freeze
        access(1'b0, 1'b1, 4'd1, 32'd2, 32'd0, 1'b0, "wr_freeze");
        pulse(8'hFF, 3);
        access(1'b0, 1'b0, 4'd1, 32'd0, 32'd2, 1'b0, "rd_ctrl_frozen");
        access(1'b0, 1'b0, 4'd9, 32'd0, 32'd0, 1'b0, "rd_cnt7_frozen");
        access(1'b0, 1'b1, 4'd1, 32'd0, 32'd0, 1'b0, "wr_unfreeze");

        // snapshot (live value without the snapshot feature) with a held response
        access(1'b0, 1'b1, 4'd1, 32'd1, 32'd0, 1'b0, "snap_pre_clr");
        pulse(8'h02, 3);
        access(1'b0, 1'b1, 4'd1, 32'd4, 32'd0, 1'b0, "wr_snap");
        pulse(8'h02, 2);
        send(1'b0, 1'b0, 4'd3, 32'd0,
`ifdef HPDCACHE_PERF_SNAPSHOT_EN
             32'd3,
`else
             32'd5,
`endif
             1'b0, 1'b1);
        recv(1'b0, "rd_snap_hold", 4);
        access(1'b0, 1'b1, 4'd1, 32'd1, 32'd0, 1'b0, "snap_clr");
        access(1'b0, 1'b0, 4'd3, 32'd0, 32'd0, 1'b0, "rd_snap_clr");

        // reset in the middle of a drain
        wbuf_empty = 1'b0;
        send(1'b0, 1'b1, 4'd0, 32'hF80B, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_drain_coal", 32'(c_coal), 32'd0);
        check("rst_drain_thr", 32'(c_thr), 32'd4);
        check("rst_drain_rsp", 32'(b.rsp_valid), 32'd0);
        check("rst_drain_ready", 32'(b.req_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wbuf_empty = 1'b1;
        access(1'b0, 1'b0, 4'd0, 32'd0, 32'h400, 1'b0, "rd_cfg_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
